// File: rtl/lsu_req_queue.sv
// lsu_req_queue: in-order load/store request queue between the AGU and the
// data cache. Requests are buffered in a DEPTH-entry FIFO and issued with a
// valid/ready handshake. Issued loads leave a small metadata record that is
// used to align and extend the matching dcache read word. A flush empties the
// request FIFO and marks in-flight loads so that their responses are dropped.
//
// Optional feature: define LSU_BYPASS_EN to let a request arriving at an empty
// queue drive the dcache port combinationally in the same cycle.

// Protocol checker: a read response must always have an outstanding load.
module lsu_req_queue_chk (
  input logic clk,
  input logic rst_n,
  input logic dc_rvalid_i,
  input logic ld_empty_i
);
  // A response with no outstanding load is ignored by the queue but flagged here.
  a_rvalid_has_load : assert property (@(posedge clk) disable iff (!rst_n)
    !(dc_rvalid_i && ld_empty_i))
    else $error("lsu_req_queue: dc_rvalid with no outstanding load");
endmodule

module lsu_req_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned LD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_awstrb,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        dc_valid,
  input  logic        dc_ready,
  output logic        dc_op,
  output logic [31:0] dc_addr,
  output logic [3:0]  dc_awstrb,
  output logic [31:0] dc_wdata,
  input  logic        dc_rvalid,
  input  logic [31:0] dc_rdata,
  output logic        ld_valid,
  output logic [31:0] ld_data
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LAW = $clog2(LD_DEPTH);

  typedef struct packed {
    logic        op;
    logic [31:0] addr;
    logic [3:0]  awstrb;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
  } req_t;

  typedef struct packed {
    logic [1:0] off;
    logic [1:0] size;
    logic       uns;
    logic       drop;
  } meta_t;

  // Select the addressed lane of the read word and sign/zero extend it.
  function automatic logic [31:0] align_load(input logic [31:0] rdata,
                                             input logic [1:0]  off,
                                             input logic [1:0]  size,
                                             input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   r = {{24{b[7] & ~uns}}, b};
      2'b01:   r = {{16{h[15] & ~uns}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  req_t              mem_q [DEPTH];
  logic [AW:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  meta_t             ld_mem_q [LD_DEPTH];
  logic [LAW:0]      ld_wptr_q, ld_wptr_d, ld_rptr_q, ld_rptr_d;
  logic              ld_valid_q, ld_valid_d;
  logic [31:0]       ld_data_q, ld_data_d;

  logic              empty_s, full_s, ld_empty_s, ld_full_s;
  logic              bypass_s, issue_ok_s, dc_hs_s, push_s, pop_s;
  logic              ld_push_s, ld_pop_s;
  logic [LAW:0]      ld_cnt_s;
  logic [LD_DEPTH-1:0] ld_live_s;
  req_t              req_in_s, head_s, sel_s;
  meta_t             resp_s;

  assign empty_s    = (wptr_q == rptr_q);
  assign full_s     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign ld_empty_s = (ld_wptr_q == ld_rptr_q);
  assign ld_full_s  = (ld_wptr_q[LAW] != ld_rptr_q[LAW]) &&
                      (ld_wptr_q[LAW-1:0] == ld_rptr_q[LAW-1:0]);
  assign ld_cnt_s   = ld_wptr_q - ld_rptr_q;

  assign req_in_s = '{op: req_op, addr: req_addr, awstrb: req_awstrb,
                      wdata: req_wdata, size: req_size, uns: req_unsigned};
  assign head_s   = mem_q[rptr_q[AW-1:0]];
  assign resp_s   = ld_mem_q[ld_rptr_q[LAW-1:0]];

`ifdef LSU_BYPASS_EN
  assign bypass_s = empty_s & ~flush & req_valid;
`else
  assign bypass_s = 1'b0;
`endif

  // Pick the entry presented to the dcache: the FIFO head, or the incoming request on bypass.
  always_comb begin
    sel_s = head_s;
    if (bypass_s) begin
      sel_s = req_in_s;
    end else begin
      sel_s = head_s;
    end
  end

  // A load may only issue while there is room to remember it; stores always may.
  assign issue_ok_s = ~(~sel_s.op & ld_full_s);
  assign dc_valid   = (bypass_s | ~empty_s) & issue_ok_s;
  assign dc_op      = sel_s.op;
  assign dc_addr    = sel_s.addr;
  assign dc_awstrb  = sel_s.awstrb;
  assign dc_wdata   = sel_s.wdata;
  assign dc_hs_s    = dc_valid & dc_ready;

  assign req_ready  = ~full_s;
  assign push_s     = req_valid & req_ready & ~flush & ~(bypass_s & dc_hs_s);
  assign pop_s      = dc_hs_s & ~bypass_s;
  assign ld_push_s  = dc_hs_s & ~sel_s.op;
  assign ld_pop_s   = dc_rvalid & ~ld_empty_s;

  // Mark which metadata slots currently hold an outstanding load.
  always_comb begin
    logic [LAW-1:0] off;
    off       = '0;
    ld_live_s = '0;
    for (int i = 0; i < int'(LD_DEPTH); i++) begin
      off          = LAW'(i) - ld_rptr_q[LAW-1:0];
      ld_live_s[i] = ({1'b0, off} < ld_cnt_s);
    end
  end

  // Next-state for pointers and the registered load result.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    ld_wptr_d  = ld_wptr_q;
    ld_rptr_d  = ld_rptr_q;
    ld_valid_d = 1'b0;
    ld_data_d  = ld_data_q;
    if (push_s) begin
      wptr_d = wptr_q + (AW+1)'(1);
    end else begin
      wptr_d = wptr_q;
    end
    if (flush) begin
      rptr_d = wptr_q;
    end else if (pop_s) begin
      rptr_d = rptr_q + (AW+1)'(1);
    end else begin
      rptr_d = rptr_q;
    end
    if (ld_push_s) begin
      ld_wptr_d = ld_wptr_q + (LAW+1)'(1);
    end else begin
      ld_wptr_d = ld_wptr_q;
    end
    if (ld_pop_s) begin
      ld_rptr_d  = ld_rptr_q + (LAW+1)'(1);
      ld_valid_d = ~resp_s.drop & ~flush;
    end else begin
      ld_rptr_d  = ld_rptr_q;
      ld_valid_d = 1'b0;
    end
    if (ld_valid_d) begin
      ld_data_d = align_load(dc_rdata, resp_s.off, resp_s.size, resp_s.uns);
    end else begin
      ld_data_d = ld_data_q;
    end
  end

  // Pointer and load-result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      ld_wptr_q  <= '0;
      ld_rptr_q  <= '0;
      ld_valid_q <= 1'b0;
      ld_data_q  <= 32'h0000_0000;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      ld_wptr_q  <= ld_wptr_d;
      ld_rptr_q  <= ld_rptr_d;
      ld_valid_q <= ld_valid_d;
      ld_data_q  <= ld_data_d;
    end
  end

  // Request storage; cleared on reset so the idle dcache fields read as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push_s) begin
      mem_q[wptr_q[AW-1:0]] <= req_in_s;
    end
  end

  // Load metadata: flush marks live entries dropped; a load issued during flush is born dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(LD_DEPTH); i++) ld_mem_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(LD_DEPTH); i++) begin
        if (flush && ld_live_s[i]) ld_mem_q[i].drop <= 1'b1;
      end
      if (ld_push_s) begin
        ld_mem_q[ld_wptr_q[LAW-1:0]] <= {sel_s.addr[1:0], sel_s.size, sel_s.uns, flush};
      end
    end
  end

  assign ld_valid = ld_valid_q;
  assign ld_data  = ld_data_q;

  lsu_req_queue_chk u_chk (
    .clk        (clk),
    .rst_n      (reset),
    .dc_rvalid_i(dc_rvalid),
    .ld_empty_i (ld_empty_s)
  );
endmodule

// File: tb/tb_lsu_req_queue.sv
// Directed self-checking bench for lsu_req_queue (default build, bypass off).
module tb_lsu_req_queue;
  logic        clk, reset, flush;
  logic        req_valid, req_ready, req_op, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_awstrb;
  logic [1:0]  req_size;
  logic        dc_valid, dc_ready, dc_op, dc_rvalid, ld_valid;
  logic [31:0] dc_addr, dc_wdata, dc_rdata, ld_data;
  logic [3:0]  dc_awstrb;
  int n_tests = 0;
  int n_fail  = 0;

  lsu_req_queue #(.DEPTH(4), .LD_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_awstrb(req_awstrb), .req_wdata(req_wdata),
    .req_size(req_size), .req_unsigned(req_unsigned),
    .dc_valid(dc_valid), .dc_ready(dc_ready), .dc_op(dc_op), .dc_addr(dc_addr),
    .dc_awstrb(dc_awstrb), .dc_wdata(dc_wdata),
    .dc_rvalid(dc_rvalid), .dc_rdata(dc_rdata),
    .ld_valid(ld_valid), .ld_data(ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic op, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata; req_awstrb = 4'hF;
  endtask

  task automatic test_reset;
    #2;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %0b want 1", req_ready); end
    n_tests++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL rst_dc_valid: got %0b want 0", dc_valid); end
    n_tests++; if (dc_addr !== 32'h0) begin n_fail++; $display("FAIL rst_dc_addr: got %h want 0", dc_addr); end
    n_tests++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ld_valid: got %0b want 0", ld_valid); end
    n_tests++; if (ld_data !== 32'h0) begin n_fail++; $display("FAIL rst_ld_data: got %h want 0", ld_data); end
    tick; tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_load_byte;
    logic [31:0] exp;
    for (int k = 0; k < 2; k++) begin
      exp = (k == 0) ? 32'hFFFF_FF80 : 32'h0000_0080;
      dc_ready = 1'b0;
      set_req(1'b0, 32'h0000_1003, 2'b00, k[0], 32'h0);
      #1;
      n_tests++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL lb_latency: dc_valid=%0b want 0", dc_valid); end
      tick; req_valid = 1'b0;
      n_tests++; if (dc_valid !== 1'b1 || dc_addr !== 32'h1003 || dc_op !== 1'b0) begin
        n_fail++; $display("FAIL lb_issue: dc_valid=%0b addr=%h op=%0b want 1/00001003/0", dc_valid, dc_addr, dc_op); end
      dc_ready = 1'b1; tick; dc_ready = 1'b0;
      n_tests++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL lb_drained: dc_valid=%0b want 0", dc_valid); end
      dc_rvalid = 1'b1; dc_rdata = 32'h80FF_0000; tick; dc_rvalid = 1'b0;
      n_tests++; if (ld_valid !== 1'b1 || ld_data !== exp) begin
        n_fail++; $display("FAIL lb_data%0d: valid=%0b data=%h want 1/%h", k, ld_valid, ld_data, exp); end
      tick;
      n_tests++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL lb_pulse: ld_valid=%0b want 0", ld_valid); end
    end
  endtask

  task automatic test_align;
    logic [31:0] addrs [4] = '{32'h2002, 32'h2000, 32'h2001, 32'h2002};
    logic [1:0]  sizes [4] = '{2'b01, 2'b01, 2'b10, 2'b00};
    logic        unss  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] rds   [4] = '{32'h8001_1234, 32'h8001_F234, 32'hDEAD_BEEF, 32'h00FE_0000};
    logic [31:0] exps  [4] = '{32'hFFFF_8001, 32'h0000_F234, 32'hDEAD_BEEF, 32'hFFFF_FFFE};
    dc_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_req(1'b0, addrs[k], sizes[k], unss[k], 32'h0);
      tick; req_valid = 1'b0;
      tick;
      dc_rvalid = 1'b1; dc_rdata = rds[k]; tick; dc_rvalid = 1'b0;
      n_tests++; if (ld_valid !== 1'b1 || ld_data !== exps[k]) begin
        n_fail++; $display("FAIL align%0d: valid=%0b data=%h want 1/%h", k, ld_valid, ld_data, exps[k]); end
    end
    dc_ready = 1'b0;
  endtask

  task automatic test_fill_drain;
    dc_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_req(1'b1, 32'h10 + 32'(4*k), 2'b10, 1'b0, 32'(k));
      #1;
      n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready%0d: got %0b want 1", k, req_ready); end
      tick;
    end
    req_valid = 1'b0;
    n_tests++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full: req_ready=%0b want 0", req_ready); end
    dc_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_tests++; if (dc_valid !== 1'b1 || dc_addr !== 32'h10 + 32'(4*k) || dc_wdata !== 32'(k) || dc_op !== 1'b1) begin
        n_fail++; $display("FAIL drain%0d: valid=%0b addr=%h wdata=%h want 1/%h/%h", k, dc_valid, dc_addr, dc_wdata, 32'h10 + 32'(4*k), k); end
      tick;
    end
    n_tests++; if (dc_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL drain_empty: dc_valid=%0b req_ready=%0b want 0/1", dc_valid, req_ready); end
    dc_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(1'b1, 32'h20 + 32'(4*k), 2'b10, 1'b0, 32'h100 + 32'(k));
      tick;
    end
    req_valid = 1'b0;
    n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL wrap_ready: got %0b want 1", req_ready); end
    dc_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_tests++; if (dc_valid !== 1'b1 || dc_addr !== 32'h20 + 32'(4*k)) begin
        n_fail++; $display("FAIL wrap%0d: valid=%0b addr=%h want 1/%h", k, dc_valid, dc_addr, 32'h20 + 32'(4*k)); end
      tick;
    end
    dc_ready = 1'b0;
  endtask

  task automatic test_ld_full;
    dc_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_req(1'b0, 32'h40 + 32'(4*k), 2'b10, 1'b0, 32'h0);
      tick;
    end
    req_valid = 1'b0;
    n_tests++; if (dc_valid !== 1'b0 || dc_addr !== 32'h50) begin
      n_fail++; $display("FAIL ldfull_stall: valid=%0b addr=%h want 0/00000050", dc_valid, dc_addr); end
    tick;
    n_tests++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL ldfull_hold: dc_valid=%0b want 0", dc_valid); end
    dc_rvalid = 1'b1; dc_rdata = 32'h1122_3344; #1;
    n_tests++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL ldfull_same: dc_valid=%0b want 0", dc_valid); end
    tick; dc_rvalid = 1'b0;
    n_tests++; if (dc_valid !== 1'b1 || ld_valid !== 1'b1 || ld_data !== 32'h1122_3344) begin
      n_fail++; $display("FAIL ldfull_release: dc_valid=%0b ld_valid=%0b data=%h want 1/1/11223344", dc_valid, ld_valid, ld_data); end
    tick;
    n_tests++; if (dc_valid !== 1'b0) begin n_fail++; $display("FAIL ldfull_issued: dc_valid=%0b want 0", dc_valid); end
    dc_rvalid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dc_rdata = 32'h1000_0000 + 32'(k);
      tick;
      n_tests++; if (ld_valid !== 1'b1 || ld_data !== 32'h1000_0000 + 32'(k)) begin
        n_fail++; $display("FAIL ldfull_resp%0d: valid=%0b data=%h", k, ld_valid, ld_data); end
    end
    dc_rvalid = 1'b0; dc_ready = 1'b0;
  endtask

  task automatic test_flush;
    dc_ready = 1'b1;
    set_req(1'b0, 32'h60, 2'b10, 1'b0, 32'h0); tick;
    set_req(1'b0, 32'h64, 2'b10, 1'b0, 32'h0); tick;
    set_req(1'b1, 32'h68, 2'b10, 1'b0, 32'h5); tick;
    dc_ready = 1'b0;
    set_req(1'b0, 32'h6C, 2'b10, 1'b0, 32'h0); tick;
    set_req(1'b1, 32'h80, 2'b10, 1'b0, 32'h9); flush = 1'b1; #1;
    n_tests++; if (dc_valid !== 1'b1 || dc_addr !== 32'h68) begin
      n_fail++; $display("FAIL flush_pre: valid=%0b addr=%h want 1/00000068", dc_valid, dc_addr); end
    tick; flush = 1'b0; req_valid = 1'b0;
    n_tests++; if (dc_valid !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++; $display("FAIL flush_empty: dc_valid=%0b req_ready=%0b want 0/1", dc_valid, req_ready); end
    dc_rvalid = 1'b1; dc_rdata = 32'h55;
    for (int k = 0; k < 2; k++) begin
      tick;
      n_tests++; if (ld_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop%0d: ld_valid=%0b want 0", k, ld_valid); end
    end
    dc_rvalid = 1'b0; dc_ready = 1'b1;
    set_req(1'b0, 32'h71, 2'b00, 1'b1, 32'h0); tick; req_valid = 1'b0;
    tick;
    dc_rvalid = 1'b1; dc_rdata = 32'h0000_AB00; tick; dc_rvalid = 1'b0;
    n_tests++; if (ld_valid !== 1'b1 || ld_data !== 32'h0000_00AB) begin
      n_fail++; $display("FAIL flush_after: valid=%0b data=%h want 1/000000ab", ld_valid, ld_data); end
    dc_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    dc_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_req(1'b1, 32'h90 + 32'(4*k), 2'b10, 1'b0, 32'h0); tick;
    end
    req_valid = 1'b0;
    n_tests++; if (dc_valid !== 1'b1 || req_ready !== 1'b0) begin
      n_fail++; $display("FAIL rmid_pre: dc_valid=%0b req_ready=%0b want 1/0", dc_valid, req_ready); end
    #2; reset = 1'b0; #1;
    n_tests++; if (dc_valid !== 1'b0 || req_ready !== 1'b1 || dc_addr !== 32'h0) begin
      n_fail++; $display("FAIL rmid_async: dc_valid=%0b req_ready=%0b addr=%h want 0/1/0", dc_valid, req_ready, dc_addr); end
    tick; reset = 1'b1; tick;
    n_tests++; if (dc_valid !== 1'b0 || ld_valid !== 1'b0) begin
      n_fail++; $display("FAIL rmid_after: dc_valid=%0b ld_valid=%0b want 0/0", dc_valid, ld_valid); end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_addr = 32'h0;
    req_awstrb = 4'h0; req_wdata = 32'h0; req_size = 2'b00; req_unsigned = 1'b0;
    dc_ready = 1'b0; dc_rvalid = 1'b0; dc_rdata = 32'h0;
    test_reset;
    test_load_byte;
    test_align;
    test_fill_drain;
    test_ld_full;
    test_flush;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
